uart_rx_sampler: RTL and testbench
==================================

# uart_rx_sampler

Oversampling serial receiver for the UART link. It recovers framed words from the asynchronous `Rx` line driven by a far-end UART transmitter and presents each word on a valid/ready interface to the consuming logic. The frame is one start bit (0), `DATA_WIDTH` data bits MSB first, and one stop bit (1). The block detects framing errors and overruns and reports each as a one-cycle pulse.

## Interface
- `DATA_WIDTH`, 32: data bits per frame.
- `CLKS_PER_BIT`, 16: `clk` cycles per serial bit. Must be even and ≥ 4.
- `clk` input 1: single clock; all logic is on its rising edge.
- `reset` input 1: asynchronous, active-high. Drives every register to its reset value immediately.
- `Rx` input 1: asynchronous serial line. Idles high.
- `rx_ready` input 1: consumer accepts `rx_data` in any cycle where `rx_valid` and `rx_ready` are both 1.
- `rx_data` output `DATA_WIDTH`: received word. Stable while `rx_valid` is 1.
- `rx_valid` output 1: word available. Held until it is accepted.
- `frame_err` output 1: one-cycle pulse when the stop bit samples 0.
- `overrun` output 1: one-cycle pulse when a good frame completes while the held word cannot be replaced.

## Operation
- **Synchronizer:** `Rx` passes through 2 flops, both reset to 1. All FSM decisions use the synchronized bit `rxs`.
- **Counters:**
  - Bit-time counter `cnt`, width `$clog2(CLKS_PER_BIT)`.
  - Bit index `idx`, width `$clog2(DATA_WIDTH+1)`.
  - Shift register `sh`, width `DATA_WIDTH`. It shifts left and inserts the sample at the LSB, so the first data bit ends up at the MSB.
- **FSM states:** IDLE, START, DATA, STOP, RECOVER. Reset state is IDLE.
- **IDLE:** `cnt`=0 and `idx`=0. If `rxs`==0, go to START.
- **START:** `cnt` increments each cycle.
  - At `cnt`==`CLKS_PER_BIT/2-1`, if `rxs`==0, clear `cnt` and go to DATA.
  - If `rxs`==1 at that point, the start was false (glitch): go to IDLE with no output activity.
- **DATA:** `cnt` increments each cycle.
  - At `cnt`==`CLKS_PER_BIT-1`: shift `rxs` into `sh`, `idx`++, `cnt`←0.
  - After the `DATA_WIDTH`-th sample, go to STOP.
- **STOP:** at `cnt`==`CLKS_PER_BIT-1`, sample `rxs`.
  - 1: good frame. Deliver it per the output rule, then go to IDLE.
  - 0: pulse `frame_err`, discard `sh`, go to RECOVER.
- **RECOVER:** wait for `rxs`==1, then go to IDLE. A line held low (break) never produces frames.
- **Output rule, applied on the good-frame cycle:**
  - If `rx_valid`==0, or `rx_valid`&`rx_ready`==1 in that same cycle, then `rx_data`←`sh` and `rx_valid`←1.
  - Otherwise pulse `overrun`; `rx_data` and `rx_valid` are unchanged and the new word is dropped.
- **Acceptance:** `rx_valid`&`rx_ready` with no load in the same cycle clears `rx_valid` on the next edge. `rx_data` keeps its last value.
- **`rx_ready` while `rx_valid`==0:** ignored.

## Timing
- **Reset values:** `rx_data`=0, `rx_valid`=0, `frame_err`=0, `overrun`=0. FSM is in IDLE and both synchronizer flops are 1.
- **Reset mid-frame:** partial data is discarded and no pulse is emitted. The first falling edge after `reset` deasserts starts a fresh frame.
- **Input latency:** 2 cycles from an `Rx` edge to `rxs`.
- **Sample points:** let cycle S be the cycle START confirms the start bit (cycle 0 is IDLE→START).
  - Data bit k (k=0 is the MSB) is sampled at cycle S+(k+1)·`CLKS_PER_BIT`.
  - The stop bit is sampled at cycle S+(`DATA_WIDTH`+1)·`CLKS_PER_BIT`.
- **Stop-bit outcome:**
  - `rx_valid` rises on the edge after the stop sample.
  - `frame_err` or `overrun` is high for exactly that one cycle.
- **Back-to-back frames:** IDLE is re-entered right after the stop sample, which is mid stop bit. A start edge arriving any time after that is caught, so tolerance is ±`CLKS_PER_BIT/2` cycles of drift per frame.
- **Throughput:** one word per (`DATA_WIDTH`+2)·`CLKS_PER_BIT` cycles. The consumer may hold `rx_ready` low for up to one full frame time without causing overrun.
- **Counter wrap:** `cnt` never exceeds `CLKS_PER_BIT-1`; `idx` never exceeds `DATA_WIDTH`.

## Test plan
All scenarios use `CLKS_PER_BIT`=16 and `DATA_WIDTH`=32.
- **Single frame:** send 0xA5A51234 at 16 clk/bit with `rx_ready`=1 → `rx_valid` high for 1 cycle, `rx_data`=0xA5A51234, `frame_err`=`overrun`=0.
- **Glitch rejection:** 4-cycle low pulse on idle `Rx` → FSM returns to IDLE, no `rx_valid`, no pulses. A following frame 0x00000001 is received correctly.
- **Framing error:** frame 0xFFFFFFFF with stop bit 0, then `Rx` held low 100 cycles, then high → one `frame_err` pulse, `rx_valid` stays 0, no new start until `Rx` returns high. Next frame 0x12345678 is received.
- **Overrun:** `rx_ready`=0, send 0x11111111 then 0x22222222 → `overrun` pulses once at the second stop sample, `rx_data` stays 0x11111111. Raising `rx_ready` clears `rx_valid` next cycle.
- **Same-cycle accept and load:** assert `rx_ready` exactly on the second frame's good-stop cycle → no `overrun`, `rx_valid` stays 1, `rx_data`=second word.
- **Reset mid-frame:** pulse `reset` during data bit 10 of 0xDEADBEEF → all outputs return to 0 immediately. A fresh 0xCAFEF00D frame is received intact, and nothing is produced for the aborted frame.

Source files
------------

// File: rtl/uart_rx_sampler.sv
// Oversampling UART receiver: start bit, DATA_WIDTH data bits MSB first, stop bit; word out on valid/ready.
// Word appears one cycle after the stop-bit sample; a good frame arriving while the held word is unaccepted is dropped with an overrun pulse.
module uart_rx_sampler #(
  parameter int DATA_WIDTH   = 32,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Rx,
  input  logic                  rx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  frame_err,
  output logic                  overrun
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, RECOVER} state_t;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [IDX_W-1:0]      idx, idx_nxt;
  logic [DATA_WIDTH-1:0] sh, sh_nxt;
  logic                  rx_meta, rxs;
  logic                  good, bad, load, accept, ovr;

  // Two-flop synchronizer; idle-high reset keeps a reset release from looking like a start edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= Rx;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      sh    <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      sh    <= sh_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    sh_nxt    = sh;
    good      = 1'b0;
    bad       = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        idx_nxt = '0;
        if (!rxs) state_nxt = START;
      end
      START: begin
        if (cnt == CNT_HALF) begin
          cnt_nxt   = '0;
          state_nxt = rxs ? IDLE : DATA;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt == CNT_FULL) begin
          cnt_nxt = '0;
          sh_nxt  = {sh[DATA_WIDTH-2:0], rxs};
          idx_nxt = idx + IDX_W'(1);
          if (idx == IDX_LAST) state_nxt = STOP;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt == CNT_FULL) begin
          cnt_nxt = '0;
          if (rxs) begin
            good      = 1'b1;
            state_nxt = IDLE;
          end else begin
            bad       = 1'b1;
            state_nxt = RECOVER;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      RECOVER: begin
        cnt_nxt = '0;
        if (rxs) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A same-cycle accept frees the holding register for the new word.
  assign accept = rx_valid & rx_ready;
  assign load   = good & (~rx_valid | rx_ready);
  assign ovr    = good & rx_valid & ~rx_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= bad;
      overrun   <= ovr;
      if (load) begin
        rx_data  <= sh;
        rx_valid <= 1'b1;
      end else if (accept) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Directed bench for uart_rx_sampler: stimulus pushes expected events, a monitor pops and checks them.
module tb_uart_rx_sampler;

  localparam int DW  = 32;
  localparam int CPB = 16;
  // Posedges from the negedge that drives the start bit to the posedge exposing the stop outcome.
  localparam int LAT = 1 + 8 + (DW + 1) * CPB + 2;

  localparam int EV_WORD = 0;
  localparam int EV_FE   = 1;
  localparam int EV_OV   = 2;

  typedef struct {
    int          kind;
    logic [31:0] data;
    longint      cyc;
  } ev_t;

  logic          clk;
  logic          reset;
  logic          Rx;
  logic          rx_ready;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          frame_err;
  logic          overrun;

  ev_t           sb[$];
  longint        pcnt;
  int            n_checks;
  int            n_fail;
  logic          prev_hold;
  logic [DW-1:0] prev_data;

  uart_rx_sampler #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .reset    (reset),
    .Rx       (Rx),
    .rx_ready (rx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial pcnt = 0;
  always @(posedge clk) pcnt <= pcnt + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, pcnt);
    end
  endtask

  task automatic push_ev(input int kind, input logic [31:0] data, input longint cyc);
    ev_t e;
    e.kind = kind;
    e.data = data;
    e.cyc  = cyc;
    sb.push_back(e);
  endtask

  task automatic expect_ev(input int kind);
    ev_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d data %h at cycle %0d, expected no event", kind, rx_data, pcnt);
    end else begin
      e = sb.pop_front();
      chk("event_kind", 64'(kind), 64'(e.kind));
      if (kind != EV_FE) chk("event_data", 64'(rx_data), 64'(e.data));
      if (e.cyc >= 0) chk("event_cycle", 64'(pcnt), 64'(e.cyc));
    end
  endtask

  // Monitor: samples mid-cycle, after the negedge-driven inputs have settled.
  initial begin
    prev_hold = 1'b0;
    prev_data = '0;
  end
  always @(negedge clk) begin
    #2;
    if (reset) begin
      prev_hold = 1'b0;
    end else begin
      if (frame_err) expect_ev(EV_FE);
      if (overrun) expect_ev(EV_OV);
      if (rx_valid && rx_ready) expect_ev(EV_WORD);
      if (prev_hold) begin
        chk("valid_held", 64'(rx_valid), 64'd1);
        chk("data_stable", 64'(rx_data), 64'(prev_data));
      end
      prev_hold = rx_valid && !rx_ready;
      prev_data = rx_data;
    end
  end

  // Must be called right after a negedge; returns on a negedge.
  task automatic drive_bit(input logic b);
    Rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [31:0] d, input logic stop);
    drive_bit(1'b0);
    for (int i = DW - 1; i >= 0; i--) drive_bit(d[i]);
    drive_bit(stop);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", pcnt);
    $fatal(1, "watchdog");
  end

  initial begin
    longint t0;
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    Rx       = 1'b1;
    rx_ready = 1'b0;
    #3;
    chk("reset_rx_valid", 64'(rx_valid), 64'd0);
    chk("reset_rx_data", 64'(rx_data), 64'd0);
    chk("reset_frame_err", 64'(frame_err), 64'd0);
    chk("reset_overrun", 64'(overrun), 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Single frame with consumer ready.
    rx_ready = 1'b1;
    t0 = pcnt;
    push_ev(EV_WORD, 32'hA5A51234, t0 + LAT);
    send_frame(32'hA5A51234, 1'b1);
    repeat (20) @(negedge clk);

    // Short low glitch must be ignored; next frame still lands.
    Rx = 1'b0;
    repeat (4) @(negedge clk);
    Rx = 1'b1;
    repeat (30) @(negedge clk);
    t0 = pcnt;
    push_ev(EV_WORD, 32'h00000001, t0 + LAT);
    send_frame(32'h00000001, 1'b1);
    repeat (20) @(negedge clk);

    // Bad stop bit followed by a 100-cycle break.
    t0 = pcnt;
    push_ev(EV_FE, 32'h0, t0 + LAT);
    send_frame(32'hFFFFFFFF, 1'b0);
    repeat (100) @(negedge clk);
    Rx = 1'b1;
    repeat (20) @(negedge clk);
    t0 = pcnt;
    push_ev(EV_WORD, 32'h12345678, t0 + LAT);
    send_frame(32'h12345678, 1'b1);
    repeat (20) @(negedge clk);

    // Overrun: two back-to-back frames with consumer stalled.
    rx_ready = 1'b0;
    send_frame(32'h11111111, 1'b1);
    t0 = pcnt;
    push_ev(EV_OV, 32'h11111111, t0 + LAT);
    send_frame(32'h22222222, 1'b1);
    repeat (10) @(negedge clk);
    push_ev(EV_WORD, 32'h11111111, -1);
    rx_ready = 1'b1;
    repeat (5) @(negedge clk);
    rx_ready = 1'b0;
    repeat (10) @(negedge clk);

    // Accept of the old word in the same cycle the new word completes.
    send_frame(32'h33333333, 1'b1);
    t0 = pcnt;
    push_ev(EV_WORD, 32'h33333333, -1);
    push_ev(EV_WORD, 32'h44444444, t0 + LAT);
    fork
      send_frame(32'h44444444, 1'b1);
      begin
        repeat (LAT - 1) @(negedge clk);
        rx_ready = 1'b1;
      end
    join
    repeat (10) @(negedge clk);
    rx_ready = 1'b0;
    repeat (10) @(negedge clk);

    // Reset during data bit 10 while a word is held.
    send_frame(32'h5A5A5A5A, 1'b1);
    repeat (5) @(negedge clk);
    chk("held_valid_before_reset", 64'(rx_valid), 64'd1);
    chk("held_data_before_reset", 64'(rx_data), 64'h5A5A5A5A);
    begin
      logic [31:0] d;
      d = 32'hDEADBEEF;
      drive_bit(1'b0);
      for (int i = DW - 1; i > DW - 11; i--) drive_bit(d[i]);
      Rx = d[DW-11];
      repeat (8) @(negedge clk);
    end
    reset = 1'b1;
    Rx    = 1'b1;
    #1;
    chk("midreset_rx_valid", 64'(rx_valid), 64'd0);
    chk("midreset_rx_data", 64'(rx_data), 64'd0);
    chk("midreset_frame_err", 64'(frame_err), 64'd0);
    chk("midreset_overrun", 64'(overrun), 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    rx_ready = 1'b1;
    t0 = pcnt;
    push_ev(EV_WORD, 32'hCAFEF00D, t0 + LAT);
    send_frame(32'hCAFEF00D, 1'b1);
    repeat (30) @(negedge clk);

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
